lif_neuron: RTL and testbench

Leaky integrate-and-fire neuron that consumes the gated synaptic weight produced by the spike-gate stage directly upstream. It accumulates weight into a membrane potential with a constant per-cycle leak and emits a one-cycle spike when the potential reaches threshold. After each spike it enters a fixed refractory period. The spike output feeds the next layer's spike-gate `add` input.

---
 rtl/snn_pkg.sv | 28 ++
 rtl/lif_refrac_timer.sv | 31 +++
 rtl/lif_neuron.sv | 92 +++++++++
 tb/tb_lif_neuron.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neural-network stages.
//   lif_state_t : neuron FSM states (INTEG, REFRAC)
//   SNN_W_W     : default synaptic weight width
//   SNN_POT_W   : default membrane potential width
//   sat_add     : unsigned add clamped to a caller-supplied maximum
package snn_pkg;

    localparam int SNN_W_W   = 4;
    localparam int SNN_POT_W = 8;

    typedef enum logic {
        INTEG  = 1'b0,
        REFRAC = 1'b1
    } lif_state_t;

    // Both operands are zero-extended to 33 bits, so the sum cannot wrap
    // before it is compared against the ceiling.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max})
            return max;
        return sum[31:0];
    endfunction

endpackage

// File: rtl/lif_refrac_timer.sv
// Loadable refractory down-counter.
//   clk  : clock
//   rst  : synchronous active-high reset (counter to 0)
//   load : load the counter with REFRAC
//   done : high during the last refractory cycle (counter == 1)
// The counter idles at 0; done is a one-cycle pulse per load when REFRAC >= 1.
module lif_refrac_timer #(
    parameter int REFRAC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int TW = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= TW'(REFRAC);
        else if (cnt != '0)
            cnt <= cnt - TW'(1);
    end

    assign done = (cnt == TW'(1));

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   in_valid    : in_weight is meaningful this cycle
//   in_weight   : unsigned excitatory weight from the upstream gate
//   spike       : registered one-cycle firing pulse
//   potential   : registered membrane potential
//   refractory  : high while the neuron is refractory
//   spike_count : saturating count of spikes since reset
//
// state  | meaning
// -------+-----------------------------------------------------------
// INTEG  | integrating: leak, add weight, fire on reaching THRESH
// REFRAC | refractory: inputs dropped, potential held at 0
module lif_neuron import snn_pkg::*; #(
    parameter int IN_W   = SNN_W_W,
    parameter int POT_W  = SNN_POT_W,
    parameter int THRESH = 16,
    parameter int LEAK   = 1,
    parameter int REFRAC = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_weight,
    output logic             spike,
    output logic [POT_W-1:0] potential,
    output logic             refractory,
    output logic [CNT_W-1:0] spike_count
);

    localparam logic [POT_W-1:0] LEAK_V   = POT_W'(LEAK);
    localparam logic [POT_W-1:0] THRESH_V = POT_W'(THRESH);
    localparam logic [31:0]      POT_MAX  = 32'({POT_W{1'b1}});

    lif_state_t       state;
    logic             timer_done;
    logic             accept;
    logic             fire;
    logic [POT_W-1:0] leaked;
    logic [IN_W-1:0]  w_eff;
    logic [POT_W-1:0] v_next;
    logic [31:0]      sum_sat;

    // The edge that ends the last refractory cycle already integrates;
    // potential is 0 there, so the normal datapath applies unchanged.
    assign accept = (state == INTEG) || timer_done;

    assign leaked  = (potential >= LEAK_V) ? (potential - LEAK_V) : '0;
    assign w_eff   = in_valid ? in_weight : '0;
    assign sum_sat = sat_add(32'(leaked), 32'(w_eff), POT_MAX);
    assign v_next  = sum_sat[POT_W-1:0];
    assign fire    = accept && (v_next >= THRESH_V);

    lif_refrac_timer #(
        .REFRAC (REFRAC)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (fire && (REFRAC > 0)),
        .done (timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INTEG;
            potential   <= '0;
            spike       <= 1'b0;
            spike_count <= '0;
        end else begin
            spike <= 1'b0;
            if (accept) begin
                if (fire) begin
                    potential <= '0;
                    spike     <= 1'b1;
                    if (spike_count != {CNT_W{1'b1}})
                        spike_count <= spike_count + CNT_W'(1);
                    state <= (REFRAC > 0) ? snn_pkg::REFRAC : INTEG;
                end else begin
                    potential <= v_next;
                    state     <= INTEG;
                end
            end else begin
                potential <= '0;
            end
        end
    end

    assign refractory = (state == snn_pkg::REFRAC);

endmodule

// File: tb/tb_lif_neuron.sv
module tb_lif_neuron;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_weight = '0;

    logic       spk0, refr0, spk1, refr1;
    logic [7:0] pot0, pot1;
    logic [7:0] cnt0;
    logic [3:0] cnt1;

    always #5 clk = ~clk;

    // default configuration
    lif_neuron dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_weight(in_weight),
        .spike(spk0), .potential(pot0), .refractory(refr0), .spike_count(cnt0)
    );

    // saturation configuration: no refractory, small counter, THRESH 15
    lif_neuron #(.CNT_W(4), .REFRAC(0), .THRESH(15)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_weight(in_weight),
        .spike(spk1), .potential(pot1), .refractory(refr1), .spike_count(cnt1)
    );

    typedef struct {
        bit spk;
        int pot;
        bit refr;
        int cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state per instance
    int mv[2];     // potential
    int ml[2];     // refractory cycles remaining
    int mc[2];     // spike count
    int th[2]   = '{16, 15};
    int rf[2]   = '{2, 0};
    int cmax[2] = '{255, 15};
    localparam int LEAK = 1;
    localparam int PMAX = 255;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit vld, input int w);
        exp_t e;
        int n;
        e.spk = 0;
        if (r) begin
            mv[i] = 0; ml[i] = 0; mc[i] = 0;
        end else if (ml[i] > 1) begin
            ml[i] = ml[i] - 1;
            mv[i] = 0;
        end else begin
            ml[i] = 0;
            n = (mv[i] >= LEAK) ? mv[i] - LEAK : 0;
            if (vld) n = n + w;
            if (n > PMAX) n = PMAX;
            if (n >= th[i]) begin
                mv[i] = 0;
                e.spk = 1;
                mc[i] = (mc[i] + 1 > cmax[i]) ? cmax[i] : mc[i] + 1;
                ml[i] = rf[i];
            end else begin
                mv[i] = n;
            end
        end
        e.pot  = mv[i];
        e.refr = (ml[i] > 0);
        e.cnt  = mc[i];
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input bit r, input bit vld, input int w);
        @(negedge clk);
        rst       = r;
        in_valid  = vld;
        in_weight = 4'(w);
        model_step(0, r, vld, w);
        model_step(1, r, vld, w);
    endtask

    // monitor: outputs are presented every cycle; compare after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("d0.spike", int'(spk0), int'(e.spk));
                check("d0.potential", int'(pot0), e.pot);
                check("d0.refractory", int'(refr0), int'(e.refr));
                check("d0.spike_count", int'(cnt0), e.cnt);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("d1.spike", int'(spk1), int'(e.spk));
                check("d1.potential", int'(pot1), e.pot);
                check("d1.refractory", int'(refr1), int'(e.refr));
                check("d1.spike_count", int'(cnt1), e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; ml[i] = 0; mc[i] = 0;
        end

        // reset with active inputs, then one idle cycle after release
        drive(1, 1, 15);
        drive(1, 1, 15);
        drive(0, 0, 0);

        // integrate to fire, then refractory drop and refire
        repeat (4) drive(0, 1, 5);
        repeat (4) drive(0, 1, 15);

        // let things settle, then leak floor
        repeat (4) drive(0, 0, 0);
        drive(0, 1, 3);
        repeat (5) drive(0, 0, 9);

        // counter saturation on dut1
        repeat (20) drive(0, 1, 15);

        // reset in the first refractory cycle of dut0
        drive(1, 0, 0);
        reached = 0;
        for (int k = 0; k < 10 && !reached; k++) begin
            drive(0, 1, 15);
            if (ml[0] == 2) reached = 1;
        end
        n_cmp++;
        if (!reached) begin
            n_bad++;
            $display("FAIL refrac_entry: got no spike expected one within 10 cycles");
        end
        drive(1, 0, 0);
        drive(0, 1, 4);
        drive(0, 0, 0);

        // random traffic with occasional resets
        for (int k = 0; k < 300; k++)
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 15)));

        drive(0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
